// File: rtl/row_readout_pkg.sv
// Shared definitions for the row readout arbiter.
//   - FSM state encoding for the grant/decode/output sequencer
//   - Code and row widths
//   - Bit positions in the corrected code word that carry the Gray row bits
//   - Gray-to-binary helper used by the decoder
package row_readout_pkg;

  localparam int unsigned ROW_CODE_W = 12;
  localparam int unsigned ROW_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDecode,
    StOut
  } row_state_e;

  // GRAY_POS[i] is the code-word bit that holds Gray bit g[i].
  localparam logic [ROW_W-1:0][3:0] GRAY_POS = {
    4'd6,   // g7
    4'd10,  // g6
    4'd9,   // g5
    4'd8,   // g4
    4'd11,  // g3
    4'd5,   // g2
    4'd4,   // g1
    4'd2    // g0
  };

  function automatic logic [ROW_W-1:0] gray_to_bin(input logic [ROW_W-1:0] g);
    logic [ROW_W-1:0] b;
    b[ROW_W-1] = g[ROW_W-1];
    for (int i = ROW_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/row_code_fix.sv
// Combinational row-word decoder.
// Build option: ROW_HAMMING_EN selects Hamming correction + Gray decode;
// without it the low 8 bits of the word pass straight through and the
// error flags are held at 0.
// Ports:
//   code  in  12-bit encoded row word
//   row   out 8-bit binary row
//   corr  out single-bit error was corrected
//   unc   out uncorrectable syndrome (13..15)
module row_code_fix
  import row_readout_pkg::*;
(
  input  logic [ROW_CODE_W-1:0] code,
  output logic [ROW_W-1:0]      row,
  output logic                  corr,
  output logic                  unc
);

`ifdef ROW_HAMMING_EN
  logic [3:0]            syn;
  logic [ROW_CODE_W-1:0] fixed;
  logic [ROW_W-1:0]      gray;

  always_comb begin
    syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6] ^ code[8] ^ code[10];
    syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6] ^ code[9] ^ code[10];
    syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6] ^ code[11];
    syn[3] = code[7] ^ code[8] ^ code[9] ^ code[10] ^ code[11];

    fixed = code;
    corr  = 1'b0;
    unc   = 1'b0;
    if (syn >= 4'd13) begin
      // Syndromes past the last code bit cannot be located; leave the word alone.
      unc = 1'b1;
    end else if (syn != 4'd0) begin
      corr = 1'b1;
      for (int unsigned i = 0; i < ROW_CODE_W; i++) begin
        if (syn == 4'(i + 1)) fixed[i] = ~code[i];
      end
    end

    for (int unsigned i = 0; i < ROW_W; i++) begin
      gray[i] = fixed[GRAY_POS[i]];
    end
    row = gray_to_bin(gray);
  end
`else
  logic unused_code_hi;
  assign unused_code_hi = ^code[ROW_CODE_W-1:ROW_W];

  assign row  = code[ROW_W-1:0];
  assign corr = 1'b0;
  assign unc  = 1'b0;
`endif

endmodule

// File: rtl/row_readout_arb.sv
// Round-robin arbiter sharing one row decoder between N requesters.
// Sequence per word: IDLE (pick) -> GRANT (gnt pulse, capture) -> DECODE
// -> OUT (hold until out_valid & out_ready). All outputs are registered.
// Build option: ROW_HAMMING_EN (inside row_code_fix) enables correction.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req[N], code[N*12]  per-requester request and encoded word
//   gnt[N]              one-hot one-cycle grant; word captured that cycle
//   row_out, src_out    decoded row and index of its requester
//   out_valid/out_ready output handshake
//   err_corr, err_unc   error flags for the presented word
//   err_clr, err_cnt    clear and saturating count of accepted error words
module row_readout_arb
  import row_readout_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            req,
  input  logic [N*ROW_CODE_W-1:0] code,
  output logic [N-1:0]            gnt,
  output logic [ROW_W-1:0]        row_out,
  output logic [$clog2(N)-1:0]    src_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_corr,
  output logic                    err_unc,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int unsigned SRC_W = $clog2(N);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N - 1);

  row_state_e            state;
  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      win;
  logic [ROW_CODE_W-1:0] code_q;

  logic [SRC_W-1:0]      pick;
  logic                  pick_vld;
  logic [ROW_W-1:0]      fix_row;
  logic                  fix_corr;
  logic                  fix_unc;
  logic                  handshake;

  // First active request at or after rr_ptr, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!pick_vld && req[(32'(rr_ptr) + k) % N]) begin
        pick_vld = 1'b1;
        pick     = SRC_W'((32'(rr_ptr) + k) % N);
      end
    end
  end

  row_code_fix u_fix (
    .code (code_q),
    .row  (fix_row),
    .corr (fix_corr),
    .unc  (fix_unc)
  );

  assign handshake = (state == StOut) && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      rr_ptr    <= '0;
      win       <= '0;
      code_q    <= '0;
      gnt       <= '0;
      row_out   <= '0;
      src_out   <= '0;
      out_valid <= 1'b0;
      err_corr  <= 1'b0;
      err_unc   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_vld) begin
            win       <= pick;
            gnt       <= '0;
            gnt[pick] <= 1'b1;
            state     <= StGrant;
          end
        end
        StGrant: begin
          gnt    <= '0;
          code_q <= code[ROW_CODE_W*win +: ROW_CODE_W];
          state  <= StDecode;
        end
        StDecode: begin
          row_out   <= fix_row;
          src_out   <= win;
          err_corr  <= fix_corr;
          err_unc   <= fix_unc;
          out_valid <= 1'b1;
          state     <= StOut;
        end
        StOut: begin
          if (handshake) begin
            out_valid <= 1'b0;
            rr_ptr    <= (win == LAST_IDX) ? '0 : win + 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      // Clear wins over a same-cycle increment.
      if (err_clr) begin
        err_cnt <= '0;
      end else if (handshake && (err_corr || err_unc) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
